// File: rtl/wb_pkg.sv
// Shared types and constants for the buffered write-back stage.
package wb_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_ADDR_W = 3;
   localparam int unsigned REG_ZERO   = 0;

   // Default-width pending-write entry; wider instances build the same layout locally.
   typedef struct packed {
      logic [DEF_ADDR_W-1:0] rd;
      logic [DEF_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_stage_buffered_if.sv
// Memory-stage handshake, register-file write port and forwarding query of the write-back stage.
interface wb_stage_buffered_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned CNT_W  = 16
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_alu_res;
   logic [DATA_W-1:0] in_mem_res;
   logic              in_sel_mem;
   logic              in_we;
   logic [ADDR_W-1:0] in_rd;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_wdata;
   logic              rf_ready;
   logic [ADDR_W-1:0] q_addr;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;
   logic [DATA_W-1:0] ans_wb;
   logic [CNT_W-1:0]  retire_count;

   modport master (
      output in_valid, in_alu_res, in_mem_res, in_sel_mem, in_we, in_rd, rf_ready, q_addr,
      input  in_ready, rf_we, rf_addr, rf_wdata, fwd_hit, fwd_data, ans_wb, retire_count
   );

   modport slave (
      input  in_valid, in_alu_res, in_mem_res, in_sel_mem, in_we, in_rd, rf_ready, q_addr,
      output in_ready, rf_we, rf_addr, rf_wdata, fwd_hit, fwd_data, ans_wb, retire_count
   );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of pending register writes with an age-ordered view (index 0 = oldest).
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = wb_entry_t
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  entry_t                 wr_entry,
   output logic                   full,
   output logic                   empty,
   output logic [DEPTH-1:0]       view_valid,
   output entry_t [DEPTH-1:0]     view
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]   count_q, count_d;
   entry_t [DEPTH-1:0] mem_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + OCC_W'(push) - OCC_W'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: every read is qualified by occupancy.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_entry;
   end

   always_comb begin
      full  = (count_q == OCC_W'(DEPTH));
      empty = (count_q == '0);
      for (int i = 0; i < DEPTH; i++) begin
         view[i]       = mem_q[rd_ptr_q + PTR_W'(i)];
         view_valid[i] = (OCC_W'(i) < count_q);
      end
   end

endmodule

// File: rtl/wb_stage_buffered.sv
// Write-back stage: result select, buffered register-file writes, forwarding and retire count.
module wb_stage_buffered
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNT_W  = 16
) (
   input logic                clk,
   input logic                reset,
   input logic                flush,
   wb_stage_buffered_if.slave bus
);

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic               accept, push, pop, discard;
   logic               full, empty;
   entry_t             wr_entry;
   logic [DEPTH-1:0]   view_valid;
   entry_t [DEPTH-1:0] view;
   logic [DATA_W-1:0]  ans_wb_q, ans_wb_d;
   logic [CNT_W-1:0]   retire_q, retire_d;

   always_comb begin
      bus.in_ready  = !full && !flush;
      accept        = bus.in_valid && bus.in_ready;
      push          = accept && bus.in_we && (bus.in_rd != ADDR_W'(REG_ZERO));
      discard       = accept && !push;
      pop           = !empty && bus.rf_ready;
      wr_entry.rd   = bus.in_rd;
      wr_entry.data = bus.in_sel_mem ? bus.in_mem_res : bus.in_alu_res;
      bus.rf_we     = !empty;
      bus.rf_addr   = empty ? '0 : view[0].rd;
      bus.rf_wdata  = empty ? '0 : view[0].data;
   end

   wb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .push       (push),
      .pop        (pop),
      .wr_entry   (wr_entry),
      .full       (full),
      .empty      (empty),
      .view_valid (view_valid),
      .view       (view)
   );

   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      bus.fwd_hit  = 1'b0;
      bus.fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (view_valid[i] && (view[i].rd == bus.q_addr) &&
             (bus.q_addr != ADDR_W'(REG_ZERO))) begin
            bus.fwd_hit  = 1'b1;
            bus.fwd_data = view[i].data;
         end
      end
   end

   always_comb begin
      ans_wb_d = pop ? view[0].data : ans_wb_q;
      retire_d = retire_q + CNT_W'(pop) + CNT_W'(discard);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ans_wb_q <= '0;
         retire_q <= '0;
      end else begin
         ans_wb_q <= ans_wb_d;
         retire_q <= retire_d;
      end
   end

   always_comb begin
      bus.ans_wb       = ans_wb_q;
      bus.retire_count = retire_q;
   end

endmodule

// File: tb/tb_wb_stage_buffered.sv
// Directed bench for wb_stage_buffered; a second, 4-bit-counter instance covers counter wrap.
module tb_wb_stage_buffered;

   logic clk;
   logic reset;
   logic flush;
   int   n_checks;
   int   n_fail;

   wb_stage_buffered_if #(.DATA_W(8), .ADDR_W(3), .CNT_W(16)) bus ();
   wb_stage_buffered_if #(.DATA_W(8), .ADDR_W(3), .CNT_W(4))  bus4 ();

   wb_stage_buffered #(.DATA_W(8), .ADDR_W(3), .DEPTH(4), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   wb_stage_buffered #(.DATA_W(8), .ADDR_W(3), .DEPTH(4), .CNT_W(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic sel, input logic [2:0] rd,
                        input logic [7:0] alu, input logic [7:0] mem);
      bus.in_valid   = v;
      bus.in_we      = we;
      bus.in_sel_mem = sel;
      bus.in_rd      = rd;
      bus.in_alu_res = alu;
      bus.in_mem_res = mem;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
   endtask

   task automatic test_reset();
      bus.rf_ready = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 3'd7, 8'h5A, 8'h00);
      step();
      idle();
      step();
      bus.rf_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 3'(i), 8'(i), 8'h00);
         step();
      end
      idle();
      bus.q_addr = 3'd3;
      #1;
      n_checks++;
      if (bus.fwd_hit !== 1'b1 || bus.ans_wb !== 8'h5A) begin
         n_fail++;
         $display("FAIL pre_reset_state: hit=%0h ans=%0h want 1 5a", bus.fwd_hit, bus.ans_wb);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %0h want 1", bus.in_ready);
      end
      n_checks++;
      if (bus.rf_we !== 1'b0) begin
         n_fail++; $display("FAIL reset_rf_we: got %0h want 0", bus.rf_we);
      end
      n_checks++;
      if (bus.rf_addr !== 3'd0 || bus.rf_wdata !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_rf_bus: addr=%0h data=%0h want 0 0", bus.rf_addr, bus.rf_wdata);
      end
      n_checks++;
      if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_fwd: hit=%0h data=%0h want 0 0", bus.fwd_hit, bus.fwd_data);
      end
      n_checks++;
      if (bus.ans_wb !== 8'h00) begin
         n_fail++; $display("FAIL reset_ans_wb: got %0h want 0", bus.ans_wb);
      end
      n_checks++;
      if (bus.retire_count !== 16'd0) begin
         n_fail++; $display("FAIL reset_retire: got %0h want 0", bus.retire_count);
      end
      step();
      reset = 1'b1;
      bus.rf_ready = 1'b1;
      step();
      n_checks++;
      if (bus.rf_we !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset: rf_we=%0h in_ready=%0h want 0 1", bus.rf_we, bus.in_ready);
      end
   endtask

   task automatic test_two_writes();
      bus.rf_ready = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 3'd2, 8'hFF, 8'hAA);
      step();
      drive(1'b1, 1'b1, 1'b1, 3'd3, 8'h55, 8'h0F);
      #1;
      n_checks++;
      if (bus.rf_we !== 1'b1 || bus.rf_addr !== 3'd2 || bus.rf_wdata !== 8'hFF) begin
         n_fail++;
         $display("FAIL first_write: we=%0h addr=%0h data=%0h want 1 2 ff",
                  bus.rf_we, bus.rf_addr, bus.rf_wdata);
      end
      step();
      idle();
      #1;
      n_checks++;
      if (bus.rf_we !== 1'b1 || bus.rf_addr !== 3'd3 || bus.rf_wdata !== 8'h0F) begin
         n_fail++;
         $display("FAIL second_write: we=%0h addr=%0h data=%0h want 1 3 f",
                  bus.rf_we, bus.rf_addr, bus.rf_wdata);
      end
      n_checks++;
      if (bus.ans_wb !== 8'hFF || bus.retire_count !== 16'd1) begin
         n_fail++;
         $display("FAIL mid_commit: ans=%0h cnt=%0h want ff 1", bus.ans_wb, bus.retire_count);
      end
      step();
      n_checks++;
      if (bus.rf_we !== 1'b0 || bus.ans_wb !== 8'h0F || bus.retire_count !== 16'd2) begin
         n_fail++;
         $display("FAIL two_writes_done: we=%0h ans=%0h cnt=%0h want 0 f 2",
                  bus.rf_we, bus.ans_wb, bus.retire_count);
      end
   endtask

   task automatic test_full();
      logic [2:0] exp_rd [3];
      logic [7:0] exp_data [3];
      exp_rd   = '{3'd3, 3'd4, 3'd5};
      exp_data = '{8'h13, 8'h14, 8'h99};
      bus.rf_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b1, 1'b0, 3'(i), 8'(8'h10 + i), 8'h00);
         step();
      end
      drive(1'b1, 1'b1, 1'b0, 3'd5, 8'h99, 8'h00);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL full_in_ready: got %0h want 0", bus.in_ready);
      end
      bus.rf_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.rf_addr !== 3'd1) begin
         n_fail++;
         $display("FAIL full_pop_cycle: in_ready=%0h addr=%0h want 0 1", bus.in_ready, bus.rf_addr);
      end
      step();
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.ans_wb !== 8'h11 || bus.rf_addr !== 3'd2) begin
         n_fail++;
         $display("FAIL after_first_pop: in_ready=%0h ans=%0h addr=%0h want 1 11 2",
                  bus.in_ready, bus.ans_wb, bus.rf_addr);
      end
      step();
      idle();
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if (bus.rf_we !== 1'b1 || bus.rf_addr !== exp_rd[k] || bus.rf_wdata !== exp_data[k]) begin
            n_fail++;
            $display("FAIL drain_order_%0d: we=%0h addr=%0h data=%0h want 1 %0h %0h", k,
                     bus.rf_we, bus.rf_addr, bus.rf_wdata, exp_rd[k], exp_data[k]);
         end
         step();
      end
      n_checks++;
      if (bus.rf_we !== 1'b0 || bus.ans_wb !== 8'h99 || bus.retire_count !== 16'd7) begin
         n_fail++;
         $display("FAIL full_drained: we=%0h ans=%0h cnt=%0h want 0 99 7",
                  bus.rf_we, bus.ans_wb, bus.retire_count);
      end
   endtask

   task automatic test_forward();
      bus.rf_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 3'd5, 8'h11, 8'h00);
      step();
      drive(1'b1, 1'b1, 1'b1, 3'd5, 8'h00, 8'h22);
      step();
      drive(1'b1, 1'b1, 1'b0, 3'd6, 8'h33, 8'h00);
      step();
      idle();
      bus.q_addr = 3'd5;
      #1;
      n_checks++;
      if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 8'h22) begin
         n_fail++;
         $display("FAIL fwd_youngest: hit=%0h data=%0h want 1 22", bus.fwd_hit, bus.fwd_data);
      end
      bus.q_addr = 3'd6;
      #1;
      n_checks++;
      if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 8'h33) begin
         n_fail++;
         $display("FAIL fwd_rd6: hit=%0h data=%0h want 1 33", bus.fwd_hit, bus.fwd_data);
      end
      bus.q_addr = 3'd0;
      #1;
      n_checks++;
      if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 8'h00) begin
         n_fail++;
         $display("FAIL fwd_zero: hit=%0h data=%0h want 0 0", bus.fwd_hit, bus.fwd_data);
      end
      bus.q_addr = 3'd1;
      #1;
      n_checks++;
      if (bus.fwd_hit !== 1'b0) begin
         n_fail++; $display("FAIL fwd_miss: hit=%0h want 0", bus.fwd_hit);
      end
      bus.rf_ready = 1'b1;
      step();
      step();
      step();
      bus.q_addr = 3'd5;
      #1;
      n_checks++;
      if (bus.rf_we !== 1'b0 || bus.fwd_hit !== 1'b0 || bus.retire_count !== 16'd10) begin
         n_fail++;
         $display("FAIL fwd_drained: we=%0h hit=%0h cnt=%0h want 0 0 a",
                  bus.rf_we, bus.fwd_hit, bus.retire_count);
      end
      bus.q_addr = 3'd0;
   endtask

   task automatic test_double_retire();
      bus.rf_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 3'd1, 8'h44, 8'h00);
      step();
      drive(1'b1, 1'b0, 1'b0, 3'd2, 8'hEE, 8'h00);
      bus.rf_ready = 1'b1;
      step();
      idle();
      #1;
      n_checks++;
      if (bus.retire_count !== 16'd12 || bus.ans_wb !== 8'h44 || bus.rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL double_retire: cnt=%0h ans=%0h we=%0h want c 44 0",
                  bus.retire_count, bus.ans_wb, bus.rf_we);
      end
      drive(1'b1, 1'b1, 1'b0, 3'd0, 8'h77, 8'h00);
      step();
      idle();
      #1;
      n_checks++;
      if (bus.retire_count !== 16'd13 || bus.rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL rd0_discard: cnt=%0h we=%0h want d 0", bus.retire_count, bus.rf_we);
      end
   endtask

   task automatic test_wrap();
      bus4.in_valid = 1'b1;
      bus4.in_we    = 1'b0;
      for (int i = 0; i < 15; i++) step();
      n_checks++;
      if (bus4.retire_count !== 4'hF) begin
         n_fail++; $display("FAIL wrap_pre: got %0h want f", bus4.retire_count);
      end
      bus4.rf_ready   = 1'b0;
      bus4.in_we      = 1'b1;
      bus4.in_rd      = 3'd1;
      bus4.in_alu_res = 8'h05;
      step();
      bus4.in_we    = 1'b0;
      bus4.rf_ready = 1'b1;
      step();
      bus4.in_valid = 1'b0;
      #1;
      n_checks++;
      if (bus4.retire_count !== 4'h1 || bus4.ans_wb !== 8'h05) begin
         n_fail++;
         $display("FAIL wrap: cnt=%0h ans=%0h want 1 5", bus4.retire_count, bus4.ans_wb);
      end
   endtask

   task automatic test_flush();
      bus.rf_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 3'd3, 8'h77, 8'h00);
      step();
      drive(1'b1, 1'b1, 1'b0, 3'd4, 8'h88, 8'h00);
      step();
      drive(1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 8'h00);
      bus.rf_ready = 1'b1;
      flush = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL flush_in_ready: got %0h want 0", bus.in_ready);
      end
      step();
      flush = 1'b0;
      idle();
      bus.q_addr = 3'd4;
      #1;
      n_checks++;
      if (bus.rf_we !== 1'b0 || bus.fwd_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_empty: we=%0h hit=%0h want 0 0", bus.rf_we, bus.fwd_hit);
      end
      n_checks++;
      if (bus.ans_wb !== 8'h77 || bus.retire_count !== 16'd14) begin
         n_fail++;
         $display("FAIL flush_commit: ans=%0h cnt=%0h want 77 e", bus.ans_wb, bus.retire_count);
      end
      step();
      n_checks++;
      if (bus.rf_we !== 1'b0 || bus.retire_count !== 16'd14) begin
         n_fail++;
         $display("FAIL flush_settled: we=%0h cnt=%0h want 0 e", bus.rf_we, bus.retire_count);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      flush    = 1'b0;
      idle();
      bus.rf_ready    = 1'b1;
      bus.q_addr      = 3'd0;
      bus4.in_valid   = 1'b0;
      bus4.in_we      = 1'b0;
      bus4.in_sel_mem = 1'b0;
      bus4.in_rd      = 3'd0;
      bus4.in_alu_res = 8'h00;
      bus4.in_mem_res = 8'h00;
      bus4.rf_ready   = 1'b1;
      bus4.q_addr     = 3'd0;
      step();
      step();
      reset = 1'b1;
      step();
      test_reset();
      test_two_writes();
      test_full();
      test_forward();
      test_double_retire();
      test_wrap();
      test_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_stage_buffered.md
# wb_stage_buffered

Parametrised write-back stage for the MIPS pipeline: selects the ALU or data-memory result per instruction, buffers pending register-file writes in a DEPTH-entry FIFO so a busy register-file port does not stall memory, forwards pending values to decode, and counts retired instructions. It sits between the data-memory stage and the register file and supersedes the fixed 8-bit, unbuffered write-back register.

## Interface
- DATA_W, 8, result/register width
- ADDR_W, 3, register address width
- DEPTH, 4, pending-write FIFO entries (power of two, ≥2)
- CNT_W, 16, retire counter width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- flush  in  1  synchronous clear of pending writes
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept
- in_alu_res  in  DATA_W  ALU result
- in_mem_res  in  DATA_W  data-memory read result
- in_sel_mem  in  1  1 = write memory result, 0 = ALU result
- in_we  in  1  instruction writes a register
- in_rd  in  ADDR_W  destination register
- rf_we  out  1  write request to register file
- rf_addr  out  ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- rf_ready  in  1  register file accepts write this cycle
- q_addr  in  ADDR_W  decode-stage forwarding query
- fwd_hit  out  1  q_addr matches a pending write
- fwd_data  out  DATA_W  youngest pending data for q_addr
- ans_wb  out  DATA_W  data of last committed write
- retire_count  out  CNT_W  retired instructions, wraps

## Operation
- Accept = in_valid && in_ready; in_ready = !full && !flush.
- Accepted entry with in_we=1 and in_rd≠0: push {in_rd, in_sel_mem ? in_mem_res : in_alu_res}.
- Accepted entry with in_we=0 or in_rd=0: not enqueued, retires on accept.
- Head drain: rf_we = !empty; rf_addr/rf_wdata = head entry; pop when rf_we && rf_ready.
- On pop: ans_wb <= head data; retire_count += 1.
- Discarded accept and pop in the same cycle: retire_count += 2. Counter wraps modulo 2^CNT_W.
- No push while full, even when a pop occurs the same cycle (in_ready already low).
- Push and pop the same cycle when not full: both occur, occupancy unchanged.
- Forwarding: combinational search of all valid entries; fwd_hit=1 if any entry rd == q_addr and q_addr≠0; fwd_data = youngest match. Otherwise fwd_hit=0, fwd_data=0.
- flush: occupancy → 0, pointers → 0 at the edge; a pop occurring in the flush cycle still commits (ans_wb, counter update); no accept in the flush cycle; retire_count not cleared.
- reset (asserted low, any time): FIFO empty, pointers 0, ans_wb=0, retire_count=0; in-flight entries lost.

## Timing
- Reset values: in_ready=1, rf_we=0, rf_addr=0, rf_wdata=0, fwd_hit=0, fwd_data=0, ans_wb=0, retire_count=0.
- Accept at edge N → rf_we visible after edge N, commit at first edge ≥N+1 with rf_ready=1.
- Pushed entry is forwardable from cycle N+1 until its pop edge.
- ans_wb and retire_count update at the pop edge (registered).
- Sustained throughput one write/cycle when rf_ready held high.

## Structure
- Package wb_pkg: entry typedef {rd[ADDR_W], data[DATA_W]}, constant REG_ZERO=0.
- Sub-module wb_fifo: DEPTH-entry circular buffer with count, head/tail pointers, flush, and a per-entry valid/rd/data view for the forwarding search.
- Top: select mux, discard logic, forwarding priority search, retire counter, ans_wb register.

## Test plan
- Reset low mid-traffic with 3 entries pending → all outputs at reset values, in_ready=1, no rf_we after release.
- Push rd=2 ALU=0xFF, rd=3 mem=0x0F (sel_mem=1), rf_ready=1 → writes (2,0xFF),(3,0x0F) on consecutive cycles, ans_wb=0x0F, retire_count=2.
- rf_ready=0, push 4 entries → in_ready=0 on 5th; raise rf_ready → drained in order, in_ready=1 after first pop.
- Pending rd=5 data 0x11 then rd=5 data 0x22, q_addr=5 → fwd_hit=1, fwd_data=0x22; q_addr=0 → fwd_hit=0.
- in_we=0 accept in same cycle as a pop → retire_count +2; with CNT_W=4 at 0xF → wraps to 0x1.
- flush with 2 pending and rf_ready=1 → head commits, other entry dropped, rf_we=0 next cycle, retire_count +1.
